// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, handshakes with instruction
// memory, and drives the IF/ID register consumed by decode.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  input  logic        jump,
  input  logic [15:0] jumpTarget,
  output logic [15:0] imemAddr,
  output logic        imemRead,
  input  logic        imemReady,
  input  logic [15:0] imemData,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus1,
  output logic        validOut
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ABORT} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] hold_buf, hold_buf_nx;
  logic [15:0] instr_nx, pc_plus1_nx;
  logic        valid_nx;
  logic        load, bubble;
  logic [15:0] load_data;
  logic        redirect;
  logic [15:0] target;

  assign redirect = jump | branchTaken;
  assign target   = jump ? jumpTarget : branchTarget;

  // Request is purely state-decoded so it falls immediately when reset asserts.
  assign imemRead = (state == FETCH);
  assign imemAddr = pc;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    hold_buf_nx = hold_buf;
    load        = 1'b0;
    bubble      = 1'b0;
    load_data   = imemData;

    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_nx  = target;
          bubble = 1'b1;
          if (!imemReady) state_nx = ABORT;
        end else if (imemReady) begin
          if (stall) begin
            hold_buf_nx = imemData;
            state_nx    = HOLD;
          end else begin
            load  = 1'b1;
            pc_nx = pc + 16'd1;
          end
        end else begin
          bubble = 1'b1;
        end
      end
      ABORT: begin
        state_nx = FETCH;
        bubble   = 1'b1;
        if (redirect) pc_nx = target;
      end
      HOLD: begin
        if (redirect) begin
          pc_nx       = target;
          hold_buf_nx = '0;
          bubble      = 1'b1;
          state_nx    = FETCH;
        end else if (!stall) begin
          load      = 1'b1;
          load_data = hold_buf;
          pc_nx     = pc + 16'd1;
          state_nx  = FETCH;
        end
      end
    endcase

    // IF/ID priority: flush over stall over load/bubble.
    instr_nx    = instruction;
    pc_plus1_nx = pcPlus1;
    valid_nx    = validOut;
    if (flush) begin
      instr_nx    = NOP_INSTR;
      pc_plus1_nx = '0;
      valid_nx    = 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_nx    = load_data;
        pc_plus1_nx = pc + 16'd1;
        valid_nx    = 1'b1;
      end else if (bubble) begin
        instr_nx = NOP_INSTR;
        valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      hold_buf    <= '0;
      instruction <= NOP_INSTR;
      pcPlus1     <= '0;
      validOut    <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      hold_buf    <= hold_buf_nx;
      instruction <= instr_nx;
      pcPlus1     <= pc_plus1_nx;
      validOut    <= valid_nx;
    end
  end

endmodule
